// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states, instruction classes and datapath select codes
// for the multi-cycle control unit.
package ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_PCWB, S_EXEC, S_WB,
        S_ADDR, S_MEMRD, S_MEMWR, S_BRCMP, S_JSAVE,
        S_JTGT, S_BRWB, S_MADDR, S_MXFER
    } state_t;

    typedef enum logic [3:0] {
        C_ADD, C_NDU, C_ADI, C_LHI, C_LW, C_SW,
        C_BEQ, C_JAL, C_JLR, C_LM, C_SM, C_NOP
    } iclass_t;

    // ALU B operand
    localparam logic [2:0] B_ZERO = 3'd0;
    localparam logic [2:0] B_RSVD = 3'd1;
    localparam logic [2:0] B_RD2  = 3'd2;
    localparam logic [2:0] B_IMM6 = 3'd3;
    localparam logic [2:0] B_CNT  = 3'd4;

    // ALU A operand
    localparam logic [2:0] A_ZERO = 3'd0;
    localparam logic [2:0] A_ONE  = 3'd1;
    localparam logic [2:0] A_LHI  = 3'd2;
    localparam logic [2:0] A_IMM6 = 3'd3;
    localparam logic [2:0] A_IMM9 = 3'd4;
    localparam logic [2:0] A_RD1  = 3'd5;
    localparam logic [2:0] A_TMPA = 3'd6;

    // Register file write enable source
    localparam logic [1:0] WEN_OFF = 2'd0;
    localparam logic [1:0] WEN_ON  = 2'd1;
    localparam logic [1:0] WEN_CZ  = 2'd2;
    localparam logic [1:0] WEN_LM  = 2'd3;

    // Register file write address
    localparam logic [2:0] WA_IR11 = 3'd0;
    localparam logic [2:0] WA_IR5  = 3'd1;
    localparam logic [2:0] WA_CNT  = 3'd2;
    localparam logic [2:0] WA_R7   = 3'd3;
    localparam logic [2:0] WA_IR8  = 3'd4;

    // Register file read port 2 address
    localparam logic [1:0] RD2_IR8 = 2'd0;
    localparam logic [1:0] RD2_CNT = 2'd1;
    localparam logic [1:0] RD2_R7  = 2'd2;

    localparam logic DIN_MEM = 1'b0;
    localparam logic DIN_T1  = 1'b1;

    localparam logic [1:0] MW_OFF  = 2'd0;
    localparam logic [1:0] MW_ON   = 2'd1;
    localparam logic [1:0] MW_LMSM = 2'd2;

    localparam logic MDIN_RD1 = 1'b0;
    localparam logic MDIN_RD2 = 1'b1;

    localparam logic ALU_ADD  = 1'b0;
    localparam logic ALU_NAND = 1'b1;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: IRout[15:12] to instruction class.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output iclass_t    iclass
);

    always_comb begin
        case (opcode)
            OP_ADD:  iclass = C_ADD;
            OP_ADI:  iclass = C_ADI;
            OP_NDU:  iclass = C_NDU;
            OP_LHI:  iclass = C_LHI;
            OP_LW:   iclass = C_LW;
            OP_SW:   iclass = C_SW;
            OP_LM:   iclass = C_LM;
            OP_SM:   iclass = C_SM;
            OP_JAL:  iclass = C_JAL;
            OP_JLR:  iclass = C_JLR;
            OP_BEQ:  iclass = C_BEQ;
            default: iclass = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore FSM sequencing the multi-cycle datapath.
// Define CTRL_LMSM_EN to include the load/store-multiple states.
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        proc_rst,
    input  logic [15:0] IRout,
    input  logic        compare,
    output logic [2:0]  Mux1_alu_B,
    output logic [2:0]  Mux2_alu_A,
    output logic [1:0]  Mux3_RF_wen,
    output logic [2:0]  Mux4_RF_wadd,
    output logic [1:0]  Mux5_RF_read2,
    output logic        Mux6_RF_dataIn,
    output logic [1:0]  Mux8_memwrite,
    output logic        Mux9_memDataIn,
    output logic        CZ_en,
    output logic        ALU_op,
    output logic        wIR,
    output logic        wAtmp,
    output logic        T1write,
    output logic [2:0]  counter
);

    state_t  state, next;
    iclass_t iclass;
    logic    unused_ir;

    assign unused_ir = ^IRout[11:0];

    ctrl_decode u_dec (
        .opcode (IRout[15:12]),
        .iclass (iclass)
    );

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) state <= S_IDLE;
        else           state <= next;
    end

`ifdef CTRL_LMSM_EN
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst)             counter <= '0;
        else if (state == S_MXFER) counter <= counter + 3'd1;
    end
`else
    assign counter = '0;
`endif

    always_comb begin
        next = S_FETCH;
        unique case (state)
            S_IDLE:  next = S_FETCH;
            S_FETCH: next = S_PCWB;
            S_PCWB: begin
                case (iclass)
                    C_ADD, C_NDU,
                    C_ADI, C_LHI: next = S_EXEC;
                    C_LW, C_SW:   next = S_ADDR;
                    C_BEQ:        next = S_BRCMP;
                    C_JAL, C_JLR: next = S_JSAVE;
`ifdef CTRL_LMSM_EN
                    C_LM, C_SM:   next = S_MADDR;
`endif
                    default:      next = S_FETCH;
                endcase
            end
            S_EXEC:  next = S_WB;
            S_ADDR:  next = (iclass == C_SW) ? S_MEMWR : S_MEMRD;
            S_BRCMP: next = compare ? S_JTGT : S_FETCH;
            S_JSAVE: next = S_JTGT;
            S_JTGT:  next = S_BRWB;
`ifdef CTRL_LMSM_EN
            S_MADDR: next = S_MXFER;
            S_MXFER: next = (counter == 3'd7) ? S_FETCH : S_MADDR;
`endif
            default: next = S_FETCH;
        endcase
    end

    always_comb begin
        Mux1_alu_B     = B_ZERO;
        Mux2_alu_A     = A_ZERO;
        Mux3_RF_wen    = WEN_OFF;
        Mux4_RF_wadd   = WA_IR11;
        Mux5_RF_read2  = RD2_IR8;
        Mux6_RF_dataIn = DIN_MEM;
        Mux8_memwrite  = MW_OFF;
        Mux9_memDataIn = MDIN_RD1;
        CZ_en          = 1'b0;
        ALU_op         = ALU_ADD;
        wIR            = 1'b0;
        wAtmp          = 1'b0;
        T1write        = 1'b0;
        unique case (state)
            S_FETCH: begin
                wIR           = 1'b1;
                T1write       = 1'b1;
                Mux5_RF_read2 = RD2_R7;
                Mux1_alu_B    = B_RD2;
                Mux2_alu_A    = A_ONE;
            end
            S_PCWB, S_BRWB: begin
                Mux3_RF_wen    = WEN_ON;
                Mux4_RF_wadd   = WA_R7;
                Mux6_RF_dataIn = DIN_T1;
                wAtmp          = (state == S_PCWB);
            end
            S_EXEC: begin
                T1write = 1'b1;
                if (iclass == C_LHI) begin
                    Mux2_alu_A = A_LHI;
                end else begin
                    Mux2_alu_A = A_RD1;
                    Mux1_alu_B = (iclass == C_ADI) ? B_IMM6 : B_RD2;
                    ALU_op     = (iclass == C_NDU) ? ALU_NAND : ALU_ADD;
                    CZ_en      = 1'b1;
                end
            end
            S_WB: begin
                Mux6_RF_dataIn = DIN_T1;
                if (iclass == C_ADD || iclass == C_NDU) begin
                    Mux3_RF_wen  = WEN_CZ;
                    Mux4_RF_wadd = WA_IR5;
                end else begin
                    Mux3_RF_wen  = WEN_ON;
                    Mux4_RF_wadd = (iclass == C_ADI) ? WA_IR8 : WA_IR11;
                end
            end
            S_ADDR: begin
                T1write    = 1'b1;
                Mux1_alu_B = B_RD2;
                Mux2_alu_A = A_IMM6;
            end
            S_MEMRD: Mux3_RF_wen = WEN_ON;
            S_MEMWR: Mux8_memwrite = MW_ON;
            S_BRCMP: begin
                Mux2_alu_A = A_RD1;
                Mux1_alu_B = B_RD2;
            end
            S_JSAVE: begin
                Mux3_RF_wen    = WEN_ON;
                Mux6_RF_dataIn = DIN_T1;
            end
            S_JTGT: begin
                T1write    = 1'b1;
                Mux1_alu_B = B_RD2;
                if (iclass == C_JLR) begin
                    Mux2_alu_A = A_ZERO;
                end else begin
                    Mux5_RF_read2 = RD2_R7;
                    Mux2_alu_A = (iclass == C_JAL) ? A_IMM9 : A_IMM6;
                end
            end
            S_MADDR: begin
                T1write    = 1'b1;
                Mux2_alu_A = A_TMPA;
                Mux1_alu_B = B_CNT;
            end
            S_MXFER: begin
                if (iclass == C_SM) begin
                    Mux8_memwrite  = MW_LMSM;
                    Mux5_RF_read2  = RD2_CNT;
                    Mux9_memDataIn = MDIN_RD2;
                end else begin
                    Mux3_RF_wen  = WEN_LM;
                    Mux4_RF_wadd = WA_CNT;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven check of the control unit state walk and selects.
// Covers CTRL_LMSM_EN on and off.
module tb_control_unit;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        proc_rst = 1'b0;
    logic [15:0] IRout = '0;
    logic        compare = 1'b0;
    logic [2:0]  Mux1_alu_B, Mux2_alu_A, Mux4_RF_wadd, counter;
    logic [1:0]  Mux3_RF_wen, Mux5_RF_read2, Mux8_memwrite;
    logic        Mux6_RF_dataIn, Mux9_memDataIn, CZ_en, ALU_op;
    logic        wIR, wAtmp, T1write;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk            (clk),
        .proc_rst       (proc_rst),
        .IRout          (IRout),
        .compare        (compare),
        .Mux1_alu_B     (Mux1_alu_B),
        .Mux2_alu_A     (Mux2_alu_A),
        .Mux3_RF_wen    (Mux3_RF_wen),
        .Mux4_RF_wadd   (Mux4_RF_wadd),
        .Mux5_RF_read2  (Mux5_RF_read2),
        .Mux6_RF_dataIn (Mux6_RF_dataIn),
        .Mux8_memwrite  (Mux8_memwrite),
        .Mux9_memDataIn (Mux9_memDataIn),
        .CZ_en          (CZ_en),
        .ALU_op         (ALU_op),
        .wIR            (wIR),
        .wAtmp          (wAtmp),
        .T1write        (T1write),
        .counter        (counter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic        cmp;
        state_t      st;
        logic [21:0] outs;
    } vec_t;

    vec_t vq[$];

    wire [21:0] outs = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen,
                        Mux4_RF_wadd, Mux5_RF_read2, Mux6_RF_dataIn,
                        Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op,
                        wIR, wAtmp, T1write};

    function automatic logic [21:0] pk(
        int m1, int m2, int m3, int m4, int m5, int m6,
        int m8, int m9, int cz, int alu, int wir, int wat, int t1);
        return {m1[2:0], m2[2:0], m3[1:0], m4[2:0], m5[1:0], m6[0],
                m8[1:0], m9[0], cz[0], alu[0], wir[0], wat[0], t1[0]};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, state_t st, logic [21:0] o,
                           int cnt);
        chk({tag, " state"}, int'(dut.state), int'(st));
        chk({tag, " outs"}, int'(outs), int'(o));
        chk({tag, " counter"}, int'(counter), cnt);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic add(logic [15:0] ir, logic c, state_t st,
                       logic [21:0] o);
        vec_t v;
        v.ir = ir; v.cmp = c; v.st = st; v.outs = o;
        vq.push_back(v);
    endtask

    logic [21:0] o_zero, o_fetch, o_pcwb, o_addr, o_brcmp;
    logic [21:0] o_jsave, o_brwb, o_maddr, o_lm, o_sm;

    task automatic add_fp(logic [15:0] ir);
        add(ir, 1'b0, S_FETCH, o_fetch);
        add(ir, 1'b0, S_PCWB, o_pcwb);
    endtask

    initial begin
        //      m1 m2 m3 m4 m5 m6 m8 m9 cz alu wir wat t1
        o_zero  = '0;
        o_fetch = pk(2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 1);
        o_pcwb  = pk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        o_addr  = pk(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        o_brcmp = pk(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_jsave = pk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        o_brwb  = pk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        o_maddr = pk(4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        o_lm    = pk(0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_sm    = pk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0);

        // ADD from reset
        add(16'h0000, 0, S_IDLE, o_zero);
        add_fp(16'h0000);
        add(16'h0000, 0, S_EXEC, pk(2,5,0,0,0,0,0,0,1,0,0,0,1));
        add(16'h0000, 0, S_WB,   pk(0,0,2,1,0,1,0,0,0,0,0,0,0));
        // LW
        add_fp(16'h4000);
        add(16'h4000, 0, S_ADDR,  o_addr);
        add(16'h4000, 0, S_MEMRD, pk(0,0,1,0,0,0,0,0,0,0,0,0,0));
        // BEQ not taken, then taken
        add_fp(16'hC000);
        add(16'hC000, 0, S_BRCMP, o_brcmp);
        add_fp(16'hC000);
        add(16'hC000, 1, S_BRCMP, o_brcmp);
        add(16'hC000, 1, S_JTGT,  pk(2,3,0,0,2,0,0,0,0,0,0,0,1));
        add(16'hC000, 1, S_BRWB,  o_brwb);
        // illegal opcode
        add_fp(16'hF000);
        // NDU, ADI, LHI
        add_fp(16'h2000);
        add(16'h2000, 0, S_EXEC, pk(2,5,0,0,0,0,0,0,1,1,0,0,1));
        add(16'h2000, 0, S_WB,   pk(0,0,2,1,0,1,0,0,0,0,0,0,0));
        add_fp(16'h1000);
        add(16'h1000, 0, S_EXEC, pk(3,5,0,0,0,0,0,0,1,0,0,0,1));
        add(16'h1000, 0, S_WB,   pk(0,0,1,4,0,1,0,0,0,0,0,0,0));
        add_fp(16'h3000);
        add(16'h3000, 0, S_EXEC, pk(0,2,0,0,0,0,0,0,0,0,0,0,1));
        add(16'h3000, 0, S_WB,   pk(0,0,1,0,0,1,0,0,0,0,0,0,0));
        // SW
        add_fp(16'h5000);
        add(16'h5000, 0, S_ADDR,  o_addr);
        add(16'h5000, 0, S_MEMWR, pk(0,0,0,0,0,0,1,0,0,0,0,0,0));
        // JAL, JLR
        add_fp(16'h8000);
        add(16'h8000, 0, S_JSAVE, o_jsave);
        add(16'h8000, 0, S_JTGT,  pk(2,4,0,0,2,0,0,0,0,0,0,0,1));
        add(16'h8000, 0, S_BRWB,  o_brwb);
        add_fp(16'h9000);
        add(16'h9000, 0, S_JSAVE, o_jsave);
        add(16'h9000, 0, S_JTGT,  pk(2,0,0,0,0,0,0,0,0,0,0,0,1));
        add(16'h9000, 0, S_BRWB,  o_brwb);

        // asynchronous reset holds everything at zero across a clock edge
        #2;
        chk_all("rst_hold", S_IDLE, o_zero, 0);
        #5;
        proc_rst = 1'b1;

        foreach (vq[i]) begin
            IRout   = vq[i].ir;
            compare = vq[i].cmp;
            #1;
            chk_all($sformatf("vec%0d", i), vq[i].st, vq[i].outs, 0);
            step();
        end

`ifdef CTRL_LMSM_EN
        // LM: eight MADDR/MXFER pairs stepping the counter
        IRout = 16'h60FF;
        #1;
        chk_all("lm_fetch", S_FETCH, o_fetch, 0);
        step();
        chk_all("lm_pcwb", S_PCWB, o_pcwb, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk_all($sformatf("lm_maddr%0d", i), S_MADDR, o_maddr, i);
            step();
            chk_all($sformatf("lm_mxfer%0d", i), S_MXFER, o_lm, i);
            step();
        end
        chk_all("lm_done", S_FETCH, o_fetch, 0);
        // SM interrupted by reset in MXFER with counter=5
        IRout = 16'h70FF;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            chk_all($sformatf("sm_maddr%0d", i), S_MADDR, o_maddr, i);
            step();
            chk_all($sformatf("sm_mxfer%0d", i), S_MXFER, o_sm, i);
            if (i < 5) step();
        end
`else
        // LM/SM are no-ops without the multi-transfer states
        IRout = 16'h6000;
        #1;
        chk_all("lm_fetch", S_FETCH, o_fetch, 0);
        step();
        chk_all("lm_pcwb", S_PCWB, o_pcwb, 0);
        step();
        chk_all("lm_nop", S_FETCH, o_fetch, 0);
        IRout = 16'h7000;
        step();
        chk_all("sm_pcwb", S_PCWB, o_pcwb, 0);
        step();
        chk_all("sm_nop", S_FETCH, o_fetch, 0);
        // ADD interrupted by reset in EXEC
        IRout = 16'h0000;
        step();
        step();
        chk_all("add_exec", S_EXEC, pk(2,5,0,0,0,0,0,0,1,0,0,0,1), 0);
`endif
        #1;
        proc_rst = 1'b0;
        #1;
        chk_all("mid_rst", S_IDLE, o_zero, 0);
        step();
        chk_all("mid_rst_edge", S_IDLE, o_zero, 0);
        #3;
        proc_rst = 1'b1;
        IRout = 16'h0000;
        step();
        chk_all("rst_release", S_FETCH, o_fetch, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port proc_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port IRout, input, 16 bits: current instruction; opcode is bits [15:12].
REQ-004 SHALL have port compare, input, 1 bit: ALU equality flag.
REQ-005 SHALL have these outputs driving datapath selects:
- Mux1_alu_B (3 bits), Mux2_alu_A (3), Mux3_RF_wen (2), Mux4_RF_wadd (3), Mux5_RF_read2 (2).
- Mux6_RF_dataIn, Mux8_memwrite (2), Mux9_memDataIn, CZ_en, ALU_op, wIR, wAtmp, T1write (1 bit each unless stated).
- counter (3 bits).

Function
REQ-006 SHALL be a Moore FSM with these states: IDLE, FETCH, PCWB, EXEC, WB, ADDR, MEMRD, MEMWR, BRCMP, JSAVE, JTGT, BRWB, MADDR, MXFER.
- Outputs SHALL decode from the state register, IRout and counter only.
- Any select not listed for a state SHALL be 0.
REQ-007 IDLE SHALL drive all outputs 0 and go to FETCH.
REQ-008 FETCH SHALL drive wIR=1, T1write=1, Mux5=2, Mux1=2, Mux2=1, ALU_op=0 (T1 <= R7+1), then go to PCWB.
REQ-009 PCWB SHALL drive Mux3=1, Mux4=3, Mux6=1 (R7 <= T1) and wAtmp=1. It SHALL then dispatch on opcode:
- 0000, 0001, 0010, 0011 -> EXEC
- 0100, 0101 -> ADDR
- 1100 -> BRCMP
- 1000, 1001 -> JSAVE
- 0110, 0111 -> MADDR
- anything else -> FETCH
REQ-010 EXEC SHALL assert T1write=1 and set the ALU as follows:
- ADD: Mux2=5, Mux1=2, ALU_op=0, CZ_en=1.
- NDU: same as ADD but ALU_op=1.
- ADI: Mux2=5, Mux1=3, CZ_en=1.
- LHI: Mux2=2, Mux1=0.
EXEC -> WB.
REQ-011 WB SHALL drive Mux6=1 and the following, then go to FETCH:
- ADD/NDU: Mux3=2, Mux4=1.
- ADI: Mux3=1, Mux4=4.
- LHI: Mux3=1, Mux4=0.
REQ-012 ADDR SHALL drive T1write=1, Mux5=0, Mux1=2, Mux2=3 (T1 <= R[IR8:6]+imm6). LW goes to MEMRD; SW goes to MEMWR.
REQ-013 MEMRD SHALL drive Mux3=1, Mux4=0, Mux6=0, then go to FETCH. MEMWR SHALL drive Mux8=1, Mux9=0, then go to FETCH.
REQ-014 BRCMP SHALL drive Mux5=0, Mux2=5, Mux1=2.
- compare=1 -> JTGT.
- compare=0 -> FETCH.
REQ-015 JSAVE SHALL drive Mux3=1, Mux4=0, Mux6=1 (link <= PC+1), then go to JTGT.
REQ-016 JTGT SHALL drive T1write=1, then go to BRWB.
- BEQ: Mux5=2, Mux1=2, Mux2=3.
- JAL: Mux5=2, Mux1=2, Mux2=4.
- JLR: Mux5=0, Mux1=2, Mux2=0.
REQ-017 BRWB SHALL drive Mux3=1, Mux4=3, Mux6=1, then go to FETCH.
REQ-018 MADDR SHALL drive T1write=1, Mux2=6, Mux1=4 (T1 <= tmpA+counter), then go to MXFER.
REQ-019 MXFER SHALL drive the following:
- LM: Mux3=3, Mux4=2, Mux6=0.
- SM: Mux8=2, Mux5=1, Mux9=1.
REQ-020 On leaving MXFER, counter SHALL increment with 3-bit wrap.
- counter was 7 -> FETCH, with counter now 0.
- otherwise -> MADDR.
REQ-021 counter SHALL hold its value in all other states, so a multi-transfer always takes exactly 16 cycles.
REQ-022 The 16-bit IRout value SHALL be consumed unchanged; latency SHALL be fixed per opcode. No handshake SHALL exist.

Reset
REQ-023 While proc_rst=0, state SHALL be IDLE, counter SHALL be 0 and every output SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-instruction SHALL abort that instruction immediately.
REQ-025 The first rising edge after reset release SHALL enter FETCH.

Configuration
REQ-026 With macro CTRL_LMSM_EN defined, MADDR/MXFER and REQ-018 to REQ-021 SHALL be present.
REQ-027 Without CTRL_LMSM_EN, opcodes 0110/0111 SHALL dispatch to FETCH as no-ops, and counter SHALL be tied to 0.

Structure
REQ-028 Package ctrl_pkg SHALL hold the opcode constants, the state enum, and named select constants for every mux input.
REQ-029 Opcode classification SHALL be one sub-module, ctrl_decode, that is combinational, maps IRout[15:12] to an instruction class, and is instantiated once.

Verification
REQ-030 Reset release with IRout=16'h0000 (ADD): states SHALL be IDLE, FETCH, PCWB, EXEC, WB, FETCH. WB SHALL show Mux3=2 and Mux4=1.
REQ-031 IRout=16'h4000 (LW): ADDR SHALL show T1write=1 and Mux2=3. MEMRD SHALL show Mux6=0 and Mux3=1. After that, state SHALL be FETCH.
REQ-032 IRout=16'hC000 (BEQ):
- compare=0 in BRCMP -> next state FETCH.
- compare=1 -> JTGT, then BRWB, with Mux4=3 in BRWB.
REQ-033 IRout=16'h60FF (LM) with CTRL_LMSM_EN: counter SHALL step 0 to 7 across 8 MADDR/MXFER pairs, then return to 0 on entering FETCH.
REQ-034 proc_rst driven low mid-MXFER with counter=5: outputs SHALL go to 0 and counter to 0 before the next clk edge.
REQ-035 IRout=16'hF000 (illegal opcode): PCWB SHALL be followed by FETCH with no RF write or memory write.
